// File: rtl/max_tracker_pkg.sv
// Shared types and constants for the max_tracker frame scanner.
package max_tracker_pkg;

  // Sample width; fixed to match the upstream comparator stage.
  localparam int DATA_W = 8;

  // Scanner states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of a frame index: $clog2(count), but never narrower than 1 bit.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/cmp_u8.sv
// Combinational unsigned magnitude comparator: eq = (a == b), gt = (a > b).
module cmp_u8
  import max_tracker_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              eq,
  output logic              gt
);

  // Both flags come straight from the operands; no state.
  always_comb begin
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/max_tracker.sv
// Frame scanner: accepts COUNT samples over valid/ready and reports the
// running maximum and its frame index with a one-cycle done pulse.
// Optional feature: define MAX_TRACKER_MIN_EN to also track the minimum
// (min_out/min_idx), updated on the same handshakes and reported with done.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; result of last frame held on outputs
// ST_FIRST | waiting for sample 0; it seeds the held max (and min)
// ST_SCAN  | comparing samples 1..COUNT-1 against the held values
// ST_DONE  | one-cycle done pulse; outputs carry the final result
module max_tracker
  import max_tracker_pkg::*;
#(
  parameter int COUNT = 8,
  localparam int IDX_W = idx_width(COUNT),
  localparam int CNT_W = $clog2(COUNT) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_out,
  output logic [IDX_W-1:0]  max_idx
`ifdef MAX_TRACKER_MIN_EN
  ,
  output logic [DATA_W-1:0] min_out,
  output logic [IDX_W-1:0]  min_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]    max_idx_q, max_idx_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  // Max path: new sample strictly above the held max replaces it; a tie or
  // a smaller sample keeps the held value so the earliest index wins.
  logic                max_eq, max_gt, max_keep;

  cmp_u8 u_cmp_max (
    .a  (in_data),
    .b  (max_q),
    .eq (max_eq),
    .gt (max_gt)
  );

`ifdef MAX_TRACKER_MIN_EN
  logic [DATA_W-1:0]   min_q, min_d;
  logic [IDX_W-1:0]    min_idx_q, min_idx_d;
  logic                min_eq, min_gt, min_keep;

  // Min path: operands swapped, so gt means the held min is above in_data.
  cmp_u8 u_cmp_min (
    .a  (min_q),
    .b  (in_data),
    .eq (min_eq),
    .gt (min_gt)
  );

  // Ties and larger samples leave the held minimum alone.
  always_comb begin
    min_keep = min_eq | ~min_gt;
  end
`endif

  // Tie-keep decision for the max path.
  always_comb begin
    max_keep = max_eq | ~max_gt;
  end

  // Next-state, counter and result update; outputs are derived from the
  // next state so they appear registered in the cycle the state is entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
`ifdef MAX_TRACKER_MIN_EN
    min_d     = min_q;
    min_idx_d = min_idx_q;
`endif
    accept    = in_valid & in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FIRST;
          cnt_d   = '0;
        end
      end

      ST_FIRST: begin
        if (accept) begin
          max_d     = in_data;
          max_idx_d = '0;
`ifdef MAX_TRACKER_MIN_EN
          min_d     = in_data;
          min_idx_d = '0;
`endif
          cnt_d     = CNT_ONE;
          state_d   = (COUNT == 1) ? ST_DONE : ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (accept) begin
          if (!max_keep) begin
            max_d     = in_data;
            max_idx_d = cnt_q[IDX_W-1:0];
          end
`ifdef MAX_TRACKER_MIN_EN
          if (!min_keep) begin
            min_d     = in_data;
            min_idx_d = cnt_q[IDX_W-1:0];
          end
`endif
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_FIRST) || (state_d == ST_SCAN);
    busy_d     = (state_d == ST_FIRST) || (state_d == ST_SCAN);
    done_d     = (state_d == ST_DONE);
  end

  // State, counter, result and output registers; reset aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      max_q      <= '0;
      max_idx_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MAX_TRACKER_MIN_EN
      min_q      <= '0;
      min_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MAX_TRACKER_MIN_EN
      min_q      <= min_d;
      min_idx_q  <= min_idx_d;
`endif
    end
  end

  // Output ports are direct flop outputs.
  always_comb begin
    in_ready = in_ready_q;
    busy     = busy_q;
    done     = done_q;
    max_out  = max_q;
    max_idx  = max_idx_q;
`ifdef MAX_TRACKER_MIN_EN
    min_out  = min_q;
    min_idx  = min_idx_q;
`endif
  end

endmodule

// File: tb/tb_max_tracker.sv
// Directed bench for max_tracker with COUNT=4.
module tb_max_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [7:0] max_out;
  logic [1:0] max_idx;
`ifdef MAX_TRACKER_MIN_EN
  logic [7:0] min_out;
  logic [1:0] min_idx;
`endif

  int total = 0;
  int bad = 0;

  max_tracker #(.COUNT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max_out  (max_out),
    .max_idx  (max_idx)
`ifdef MAX_TRACKER_MIN_EN
    ,
    .min_out  (min_out),
    .min_idx  (min_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until the handshake edge has passed.
  task automatic put(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("put_timeout", (n < 20), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] m, input logic [1:0] i);
    check({tag, "_done"}, done, 1);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_max"}, max_out, m);
    check({tag, "_idx"}, max_idx, i);
  endtask

  initial begin
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_max", max_out, 0);
    check("rst_idx", max_idx, 0);
    step();
    rst = 1'b0;
    step();

    // in_valid in IDLE is not accepted
    in_valid = 1'b1; in_data = 8'hAA;
    step();
    check("idle_ignore_max", max_out, 0);
    check("idle_ignore_busy", busy, 0);
    in_valid = 1'b0;

    // Basic frame 3,9,5,7
    start = 1'b1;
    step();
    start = 1'b0;
    check("b_busy", busy, 1);
    check("b_ready", in_ready, 1);
    put(8'd3); put(8'd9); put(8'd5);
    check("b_not_done", done, 0);
    put(8'd7);
    check_result("basic", 8'd9, 2'd1);
    step();
    check("b_done_pulse", done, 0);
    check("b_hold_max", max_out, 9);

    // Ties 8,8,2,8 with start held high throughout
    start = 1'b1;
    step();
    put(8'd8); put(8'd8); put(8'd2); put(8'd8);
    check_result("ties", 8'd8, 2'd0);
    step();
    check("t_idle_busy", busy, 0);
    check("t_idle_done", done, 0);
    step();
    check("t_restart_busy", busy, 1);
    check("t_restart_ready", in_ready, 1);
    start = 1'b0;

    // Gappy frame 0x10,0xFF,0x80,0xFE with two idle cycles between samples
    put(8'h10); step(); step();
    put(8'hFF); step(); step();
    put(8'h80); step(); step();
    check("g_mid_busy", busy, 1);
    check("g_mid_done", done, 0);
    check("g_mid_max", max_out, 8'hFF);
    put(8'hFE);
    check_result("gappy", 8'hFF, 2'd1);
    step();

    // Extremes: all zeros
    start = 1'b1; step(); start = 1'b0;
    check("z_hold_max", max_out, 8'hFF);
    put(8'd0); put(8'd0); put(8'd0); put(8'd0);
    check_result("zeros", 8'd0, 2'd0);
    step();

    // Second frame 1,2,3,255
    start = 1'b1; step(); start = 1'b0;
    put(8'd1); put(8'd2); put(8'd3); put(8'd255);
    check_result("rise", 8'd255, 2'd3);
    step(); step();
    check("h_idle_max", max_out, 255);
    check("h_idle_idx", max_idx, 3);

    // Next frame: result holds until first accept, start in SCAN ignored
    start = 1'b1; step(); start = 1'b0;
    check("h_first_max", max_out, 255);
    check("h_first_idx", max_idx, 3);
    put(8'd4);
    check("r_first_max", max_out, 4);
    check("r_first_idx", max_idx, 0);
    start = 1'b1; step(); start = 1'b0;
    check("r_start_busy", busy, 1);
    check("r_start_ready", in_ready, 1);
    put(8'd1);
    check("r_two_max", max_out, 4);

    // Asynchronous reset mid-frame
    #2 rst = 1'b1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_ready", in_ready, 0);
    check("mr_max", max_out, 0);
    check("mr_idx", max_idx, 0);
    check("mr_done", done, 0);
    step();
    rst = 1'b0;
    step();
    check("mr_no_done", done, 0);
    check("mr_idle_busy", busy, 0);

    // New frame after reset 4,1,6,2
    start = 1'b1; step(); start = 1'b0;
    put(8'd4); put(8'd1); put(8'd6); put(8'd2);
    check_result("post_rst", 8'd6, 2'd2);
    step();

`ifdef MAX_TRACKER_MIN_EN
    // Min tracking 5,2,9,2
    start = 1'b1; step(); start = 1'b0;
    put(8'd5); put(8'd2); put(8'd9); put(8'd2);
    check_result("minmax", 8'd9, 2'd2);
    check("mm_min", min_out, 2);
    check("mm_min_idx", min_idx, 1);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
